// File: rtl/cvm_dispense_ctrl_if.sv
// rtl/cvm_dispense_ctrl_if.sv - vend request, sensor and actuator bundle of the dispense sequencer
interface cvm_dispense_ctrl_if;
  logic vend_req;
  logic sugar_sel;
  logic cup_present;
  logic water_ready;
  logic clr_fault;
  logic vend_ack;
  logic vend_drop;
  logic busy;
  logic cup_drop;
  logic sugar_valve;
  logic pump_on;
  logic done;
  logic fault;

  modport master (
    output vend_req, sugar_sel, cup_present, water_ready, clr_fault,
    input  vend_ack, vend_drop, busy, cup_drop, sugar_valve, pump_on, done, fault
  );

  modport slave (
    input  vend_req, sugar_sel, cup_present, water_ready, clr_fault,
    output vend_ack, vend_drop, busy, cup_drop, sugar_valve, pump_on, done, fault
  );
endinterface

// File: rtl/cvm_dispense_ctrl.sv
// rtl/cvm_dispense_ctrl.sv - cup/sugar/brew dispense sequencer with one-deep order queue
module cvm_dispense_ctrl #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned CUP_CYC   = 4,
  parameter int unsigned CUP_TMO   = 16,
  parameter int unsigned SUGAR_CYC = 8,
  parameter int unsigned BREW_CYC  = 32
) (
  input logic clk,
  input logic rst,
  cvm_dispense_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CUP, S_WAIT_CUP, S_SUGAR, S_BREW, S_DONE, S_FAULT
  } state_t;

  localparam logic [CNT_W-1:0] CUP_END   = CNT_W'(CUP_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_END   = CNT_W'(CUP_TMO - 1);
  localparam logic [CNT_W-1:0] SUGAR_END = CNT_W'(SUGAR_CYC - 1);
  localparam logic [CNT_W-1:0] BREW_END  = CNT_W'(BREW_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             sugar_q, sugar_d;
  logic             pend_q, pend_d;
  logic             pend_sugar_q, pend_sugar_d;
  logic             ack_q, ack_d;
  logic             drop_q, drop_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      sugar_q      <= 1'b0;
      pend_q       <= 1'b0;
      pend_sugar_q <= 1'b0;
      ack_q        <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      sugar_q      <= sugar_d;
      pend_q       <= pend_d;
      pend_sugar_q <= pend_sugar_d;
      ack_q        <= ack_d;
      drop_q       <= drop_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sugar_d      = sugar_q;
    pend_d       = pend_q;
    pend_sugar_d = pend_sugar_q;
    ack_d        = 1'b0;
    drop_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.vend_req) begin
          state_d = S_CUP;
          sugar_d = bus.sugar_sel;
        end
      end
      S_CUP: begin
        if (timer_q == CUP_END) state_d = S_WAIT_CUP;
      end
      S_WAIT_CUP: begin
        if (bus.cup_present)         state_d = sugar_q ? S_SUGAR : S_BREW;
        else if (timer_q == TMO_END) state_d = S_FAULT;
      end
      S_SUGAR: begin
        if (!bus.cup_present)          state_d = S_FAULT;
        else if (timer_q == SUGAR_END) state_d = S_BREW;
      end
      S_BREW: begin
        if (!bus.cup_present)                            state_d = S_FAULT;
        else if (bus.water_ready && timer_q == BREW_END) state_d = S_DONE;
      end
      S_DONE: begin
        if (pend_q) begin
          state_d = S_CUP;
          sugar_d = pend_sugar_q;
          pend_d  = 1'b0;
        end else if (bus.vend_req) begin
          // an order landing on DONE with an empty queue goes straight to the next cup
          state_d = S_CUP;
          sugar_d = bus.sugar_sel;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FAULT: begin
        if (bus.clr_fault) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.vend_req) begin
      if (state_q == S_IDLE) begin
        ack_d = 1'b1;
      end else if (state_q == S_FAULT || state_d == S_FAULT || pend_q) begin
        drop_d = 1'b1;
      end else begin
        ack_d = 1'b1;
        if (state_q != S_DONE) begin
          pend_d       = 1'b1;
          pend_sugar_d = bus.sugar_sel;
        end
      end
    end

    if (state_d == S_FAULT && state_q != S_FAULT) pend_d = 1'b0;
  end

  // brew time is measured in boiler-ready cycles only
  always_comb begin
    timer_d = timer_q + 1'b1;
    if (state_d != state_q || state_q == S_IDLE || state_q == S_FAULT)
      timer_d = '0;
    else if (state_q == S_BREW)
      timer_d = timer_q + {{(CNT_W-1){1'b0}}, bus.water_ready};
  end

  assign bus.vend_ack    = ack_q;
  assign bus.vend_drop   = drop_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.cup_drop    = (state_q == S_CUP);
  assign bus.sugar_valve = (state_q == S_SUGAR);
  assign bus.pump_on     = (state_q == S_BREW) && bus.water_ready;
  assign bus.done        = (state_q == S_DONE);
  assign bus.fault       = (state_q == S_FAULT);

endmodule

// File: tb/tb_cvm_dispense_ctrl.sv
// tb/tb_cvm_dispense_ctrl.sv - directed bench with a phase/countdown model of the dispenser
module tb_cvm_dispense_ctrl;
  localparam int CUP_CYC = 4, CUP_TMO = 16, SUGAR_CYC = 8, BREW_CYC = 32;
  localparam int M_IDLE = 0, M_CUP = 1, M_WAIT = 2, M_SUGAR = 3, M_BREW = 4, M_DONE = 5, M_FAULT = 6;

  logic clk;
  logic rst;
  cvm_dispense_ctrl_if bus();

  cvm_dispense_ctrl #(
    .CNT_W(8), .CUP_CYC(CUP_CYC), .CUP_TMO(CUP_TMO), .SUGAR_CYC(SUGAR_CYC), .BREW_CYC(BREW_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int ticks, first_done, last_done, first_fault;
  int cnt_cup, cnt_sugar, cnt_pump, cnt_done, cnt_ack, cnt_drop;

  int m_phase, m_left;
  bit m_sugar, m_pend, m_pend_sugar, m_ack, m_drop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = M_IDLE; m_left = 0; m_sugar = 0; m_pend = 0; m_pend_sugar = 0;
    m_ack = 0; m_drop = 0;
  endtask

  task automatic model_step();
    int nxt;
    bit ack, drop, pend0, vr, ss, cp, wr;
    vr = bus.vend_req; ss = bus.sugar_sel; cp = bus.cup_present; wr = bus.water_ready;
    nxt = m_phase; ack = 0; drop = 0; pend0 = m_pend;
    case (m_phase)
      M_IDLE: if (vr) begin nxt = M_CUP; m_left = CUP_CYC; m_sugar = ss; end
      M_CUP: begin
        m_left--;
        if (m_left == 0) begin nxt = M_WAIT; m_left = CUP_TMO; end
      end
      M_WAIT: begin
        if (cp) begin
          nxt = m_sugar ? M_SUGAR : M_BREW;
          m_left = m_sugar ? SUGAR_CYC : BREW_CYC;
        end else begin
          m_left--;
          if (m_left == 0) nxt = M_FAULT;
        end
      end
      M_SUGAR: begin
        if (!cp) nxt = M_FAULT;
        else begin
          m_left--;
          if (m_left == 0) begin nxt = M_BREW; m_left = BREW_CYC; end
        end
      end
      M_BREW: begin
        if (!cp) nxt = M_FAULT;
        else if (wr) begin
          m_left--;
          if (m_left == 0) nxt = M_DONE;
        end
      end
      M_DONE: begin
        if (pend0) begin nxt = M_CUP; m_left = CUP_CYC; m_sugar = m_pend_sugar; m_pend = 0; end
        else if (vr) begin nxt = M_CUP; m_left = CUP_CYC; m_sugar = ss; end
        else nxt = M_IDLE;
      end
      default: if (bus.clr_fault) nxt = M_IDLE;
    endcase
    if (vr) begin
      if (m_phase == M_IDLE) ack = 1;
      else if (m_phase == M_FAULT || nxt == M_FAULT || pend0) drop = 1;
      else begin
        ack = 1;
        if (m_phase != M_DONE) begin m_pend = 1; m_pend_sugar = ss; end
      end
    end
    if (nxt == M_FAULT && m_phase != M_FAULT) m_pend = 0;
    m_phase = nxt; m_ack = ack; m_drop = drop;
  endtask

  task automatic compare_all();
    chk("busy",        bus.busy,        (m_phase != M_IDLE));
    chk("cup_drop",    bus.cup_drop,    (m_phase == M_CUP));
    chk("sugar_valve", bus.sugar_valve, (m_phase == M_SUGAR));
    chk("pump_on",     bus.pump_on,     (m_phase == M_BREW) && bus.water_ready);
    chk("done",        bus.done,        (m_phase == M_DONE));
    chk("fault",       bus.fault,       (m_phase == M_FAULT));
    chk("vend_ack",    bus.vend_ack,    m_ack);
    chk("vend_drop",   bus.vend_drop,   m_drop);
    cnt_cup   += int'(bus.cup_drop);
    cnt_sugar += int'(bus.sugar_valve);
    cnt_pump  += int'(bus.pump_on);
    cnt_done  += int'(bus.done);
    cnt_ack   += int'(bus.vend_ack);
    cnt_drop  += int'(bus.vend_drop);
    if (bus.done === 1'b1) begin
      if (first_done == 0) first_done = ticks;
      last_done = ticks;
    end
    if (bus.fault === 1'b1 && first_fault == 0) first_fault = ticks;
  endtask

  // ticks==k before a call means the edge taken is Ek of the current test
  task automatic tick();
    @(posedge clk);
    ticks++;
    if (!rst) model_reset(); else model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic start_test();
    ticks = 0; first_done = 0; last_done = 0; first_fault = 0;
    cnt_cup = 0; cnt_sugar = 0; cnt_pump = 0; cnt_done = 0; cnt_ack = 0; cnt_drop = 0;
  endtask

  task automatic vend(input bit s);
    bus.vend_req = 1; bus.sugar_sel = s;
    tick();
    bus.vend_req = 0; bus.sugar_sel = 0;
  endtask

  initial begin
    rst = 0;
    bus.vend_req = 0; bus.sugar_sel = 0; bus.cup_present = 0;
    bus.water_ready = 1; bus.clr_fault = 0;
    model_reset();
    start_test();
    tick(); tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_outs", {bus.cup_drop, bus.sugar_valve, bus.pump_on, bus.done, bus.fault,
                     bus.vend_ack, bus.vend_drop}, 0);
    rst = 1;
    tick();

    // 1: sugared cup, cup sensed from E5
    start_test();
    vend(1);
    while (ticks < 60) begin bus.cup_present = (ticks >= 5); tick(); end
    chk("t1_cup_cycles", cnt_cup, 4);
    chk("t1_sugar_cycles", cnt_sugar, 8);
    chk("t1_pump_cycles", cnt_pump, 32);
    chk("t1_done_count", cnt_done, 1);
    chk("t1_done_time", first_done, 46);
    chk("t1_ack_count", cnt_ack, 1);
    bus.cup_present = 0;

    // 2: no cup ever -> timeout fault, order during fault dropped, then clear
    start_test();
    vend(0);
    while (ticks < 25) tick();
    chk("t2_fault_time", first_fault, 21);
    chk("t2_fault_held", bus.fault, 1);
    vend(1);
    tick();
    chk("t2_drop_count", cnt_drop, 1);
    chk("t2_ack_count", cnt_ack, 1);
    bus.clr_fault = 1; tick(); bus.clr_fault = 0; tick();
    chk("t2_busy_after_clr", bus.busy, 0);
    chk("t2_fault_after_clr", bus.fault, 0);

    // 3: boiler not ready for 10 cycles of brew
    start_test();
    bus.cup_present = 1;
    vend(0);
    while (ticks < 60) begin bus.water_ready = !(ticks >= 15 && ticks < 25); tick(); end
    chk("t3_pump_cycles", cnt_pump, 32);
    chk("t3_done_time", first_done, 48);
    chk("t3_done_count", cnt_done, 1);

    // 4: queued order during brew runs right after DONE, third order dropped
    start_test();
    vend(0);
    while (ticks < 95) begin
      bus.vend_req = (ticks == 10 || ticks == 12);
      bus.sugar_sel = (ticks == 10);
      tick();
    end
    bus.vend_req = 0; bus.sugar_sel = 0;
    chk("t4_done_count", cnt_done, 2);
    chk("t4_first_done", first_done, 38);
    chk("t4_second_done", last_done, 84);
    chk("t4_ack_count", cnt_ack, 2);
    chk("t4_drop_count", cnt_drop, 1);
    chk("t4_sugar_cycles", cnt_sugar, 8);
    chk("t4_pump_cycles", cnt_pump, 64);
    chk("t4_idle_end", bus.busy, 0);

    // 5: cup removed mid-sugar with an order queued
    start_test();
    bus.cup_present = 0;
    vend(1);
    while (ticks < 15) begin
      bus.cup_present = (ticks >= 5 && ticks < 9);
      bus.vend_req = (ticks == 7);
      tick();
    end
    bus.vend_req = 0;
    chk("t5_fault_time", first_fault, 10);
    chk("t5_fault_held", bus.fault, 1);
    chk("t5_valve_off", bus.sugar_valve, 0);
    chk("t5_sugar_cycles", cnt_sugar, 4);
    bus.clr_fault = 1; bus.cup_present = 1; tick(); bus.clr_fault = 0;
    while (ticks < 80) tick();
    chk("t5_queue_lost", cnt_done, 0);
    chk("t5_idle", bus.busy, 0);
    chk("t5_ack_count", cnt_ack, 2);

    // 6: asynchronous reset mid-brew
    start_test();
    vend(0);
    while (ticks < 20) tick();
    chk("t6_pump_before", bus.pump_on, 1);
    #2;
    rst = 0;
    model_reset();
    #1;
    chk("t6_pump_async", bus.pump_on, 0);
    chk("t6_busy_async", bus.busy, 0);
    tick(); tick();
    rst = 1;
    while (ticks < 70) tick();
    chk("t6_no_done", cnt_done, 0);
    chk("t6_idle", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
